inet_checksum: RTL

Streaming one's-complement (RFC 1071) checksum engine for the networking path. It supersedes the single-byte IPv4 header checksum with a parametrised datapath width, explicit frame delimiting and odd-length handling. Back-to-back frames are supported through a pipelined fold stage. It sits beside the IPv4/UDP framers and consumes the same byte stream they emit, most-significant byte first.

---
 rtl/inet_checksum_pkg.sv | 20 ++
 rtl/inet_checksum_fold.sv | 25 ++
 rtl/inet_checksum.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/inet_checksum_pkg.sv
// Shared constants and types for the streaming one's-complement checksum engine.
package inet_checksum_pkg;

    localparam int unsigned BYTE_LEN           = 8;
    localparam int unsigned CKSUM_W            = 16;
    localparam int unsigned ACC_W_DEF          = 32;
    localparam int unsigned BYTES_PER_BEAT_DEF = 1;
    localparam int unsigned NBYTES_W_DEF       = $clog2(BYTES_PER_BEAT_DEF) + 1;

    // Width of the valid-byte count for a given beat size (counts 1..bpb).
    function automatic int unsigned nbytes_w(input int unsigned bpb);
        return $clog2(bpb) + 1;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/inet_checksum_fold.sv
// cksum_fold: combinational end-around fold of a wide binary sum down to 16 bits.
//   i_acc   : ACC_W-bit plain binary accumulation of 16-bit words
//   o_sum_c : 16-bit one's-complement sum (not complemented)
module cksum_fold
    import inet_checksum_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]   i_acc,
    output logic [CKSUM_W-1:0] o_sum_c
);

    localparam int unsigned HI_W = ACC_W - CKSUM_W;
    localparam int unsigned S1_W = ((HI_W > CKSUM_W) ? HI_W : CKSUM_W) + 1;
    localparam int unsigned S2_W = CKSUM_W + 1;

    logic [S1_W-1:0] w_s1;
    logic [S2_W-1:0] w_s2;

    // Low half plus high part, then two end-around carry folds.
    assign w_s1    = S1_W'(i_acc[CKSUM_W-1:0]) + S1_W'(i_acc[ACC_W-1:CKSUM_W]);
    assign w_s2    = S2_W'(w_s1[CKSUM_W-1:0]) + S2_W'(w_s1[S1_W-1:CKSUM_W]);
    assign o_sum_c = w_s2[CKSUM_W-1:0] + CKSUM_W'(w_s2[CKSUM_W]);

endmodule

// File: rtl/inet_checksum.sv
// inet_checksum: streaming RFC 1071 checksum over MSB-first byte beats.
//   clk, rst (sync, active-high)
//   in_valid/in_first/in_last : beat qualifier and frame delimiters
//   in_data   : BYTES_PER_BEAT bytes, top byte is earliest on the wire
//   in_nbytes : valid bytes on the last beat (1..BYTES_PER_BEAT)
//   busy      : frame in progress
//   out_valid : one-cycle result strobe, two cycles after the last beat
//   out_sum   : complemented one's-complement sum, held between strobes
//   out_ok    : out_sum == 0 when INET_CKSUM_VERIFY_EN is defined, else 0
module inet_checksum #(
    parameter int unsigned BYTE_LEN       = inet_checksum_pkg::BYTE_LEN,
    parameter int unsigned BYTES_PER_BEAT = inet_checksum_pkg::BYTES_PER_BEAT_DEF,
    parameter int unsigned ACC_W          = inet_checksum_pkg::ACC_W_DEF
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  in_valid,
    input  logic                                                  in_first,
    input  logic                                                  in_last,
    input  logic [BYTES_PER_BEAT*BYTE_LEN-1:0]                    in_data,
    input  logic [inet_checksum_pkg::nbytes_w(BYTES_PER_BEAT)-1:0] in_nbytes,
    output logic                                                  busy,
    output logic                                                  out_valid,
    output logic [inet_checksum_pkg::CKSUM_W-1:0]                 out_sum,
    output logic                                                  out_ok
);

    import inet_checksum_pkg::*;

    localparam int unsigned NB_W = nbytes_w(BYTES_PER_BEAT);

    state_t             r_state, w_state_nxt;
    logic [ACC_W-1:0]   r_acc, w_acc_nxt, w_beat_sum, w_acc_beat, r_fold_acc;
    logic               r_par, w_par_nxt, w_par_start, w_par_beat, w_snap;
    logic [NB_W-1:0]    w_nbytes;
    logic               r_fold_vld, r_valid;
    logic [CKSUM_W-1:0] w_folded, r_sum;

    // Contribution of the current beat; even frame offsets land in the high half.
    always_comb begin
        w_nbytes    = in_last ? in_nbytes : NB_W'(BYTES_PER_BEAT);
        w_par_start = in_first ? 1'b0 : r_par;
        w_beat_sum  = '0;
        for (int k = 0; k < BYTES_PER_BEAT; k++) begin
            if (NB_W'(k) < w_nbytes) begin
                if ((w_par_start ^ k[0]) == 1'b0)
                    w_beat_sum = w_beat_sum
                        + (ACC_W'(in_data[(BYTES_PER_BEAT-1-k)*BYTE_LEN +: BYTE_LEN]) << BYTE_LEN);
                else
                    w_beat_sum = w_beat_sum
                        + ACC_W'(in_data[(BYTES_PER_BEAT-1-k)*BYTE_LEN +: BYTE_LEN]);
            end
        end
        w_par_beat = w_par_start ^ w_nbytes[0];
        w_acc_beat = (in_first ? '0 : r_acc) + w_beat_sum;
    end

    // Frame FSM: in_first always restarts, in_last hands the snapshot to the fold stage.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_par_nxt   = r_par;
        w_snap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && in_first) begin
                    if (in_last) begin
                        w_snap = 1'b1;
                    end else begin
                        w_state_nxt = ST_ACCUM;
                        w_acc_nxt   = w_acc_beat;
                        w_par_nxt   = w_par_beat;
                    end
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    if (in_last) begin
                        w_snap      = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_acc_nxt   = '0;
                        w_par_nxt   = 1'b0;
                    end else begin
                        w_acc_nxt = w_acc_beat;
                        w_par_nxt = w_par_beat;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_par   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_par   <= w_par_nxt;
        end
    end

    cksum_fold #(.ACC_W(ACC_W)) u_fold (
        .i_acc   (r_fold_acc),
        .o_sum_c (w_folded)
    );

    // Fold stage runs independently so a new frame can start while a result is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fold_vld <= 1'b0;
            r_fold_acc <= '0;
            r_valid    <= 1'b0;
            r_sum      <= '0;
        end else begin
            r_fold_vld <= w_snap;
            if (w_snap)
                r_fold_acc <= w_acc_beat;
            r_valid <= r_fold_vld;
            if (r_fold_vld)
                r_sum <= ~w_folded;
        end
    end

`ifdef INET_CKSUM_VERIFY_EN
    logic r_ok;

    // Received header with its checksum field included sums to zero when intact.
    always_ff @(posedge clk) begin
        if (rst)
            r_ok <= 1'b0;
        else if (r_fold_vld)
            r_ok <= ((~w_folded) == '0);
    end

    assign out_ok = r_ok;
`else
    assign out_ok = 1'b0;
`endif

    assign busy      = (r_state == ST_ACCUM);
    assign out_valid = r_valid;
    assign out_sum   = r_sum;

endmodule
